// File: rtl/tick_pkg.sv
// Shared definitions for the multi-channel tick generator: channel state
// encoding, default sizing and the packed period slice offset.
package tick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tick_state_e;

    localparam int TICK_N_CH_DEF  = 4;
    localparam int TICK_CNT_W_DEF = 26;

    // Low bit of channel ch's period inside the packed max_count bus.
    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: IDLE/RUN FSM, up-counter and latched period register.
//
//   state | meaning
//   IDLE  | not counting; counter held at 0, tick low
//   RUN   | counting up to the latched period, tick on terminal count
module tick_channel
    import tick_pkg::*;
#(
    parameter int CNT_W = TICK_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ch_en,
    input  logic             oneshot,
    input  logic             start,
    input  logic [CNT_W-1:0] max_count,
    output logic             tick,
    output logic             busy
);

    tick_state_e      state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] period, period_nxt;
    logic             tick_nxt;
    logic             term;
    logic             enter;

    assign term  = (count == period);
    // Entering (or restarting) RUN: explicit start, or a periodic channel waking up.
    assign enter = start || (state == IDLE && !oneshot);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            period <= '0;
            tick   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            period <= period_nxt;
            tick   <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!ch_en) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    if (!oneshot) state_nxt = RUN;
                RUN:     if (term && oneshot) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt  = count;
        period_nxt = period;
        tick_nxt   = 1'b0;
        if (!ch_en) begin
            count_nxt = '0;
        end else if (enter) begin
            count_nxt  = '0;
            period_nxt = max_count;
        end else if (state == RUN) begin
            if (term) begin
                tick_nxt  = 1'b1;
                count_nxt = '0;
                if (!oneshot) period_nxt = max_count;
            end else begin
                count_nxt = count + CNT_W'(1);
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: N_CH independent periodic/one-shot channels,
// each taking its period from its own slice of the packed max_count bus.
module multi_tick_gen
    import tick_pkg::*;
#(
    parameter int N_CH  = TICK_N_CH_DEF,
    parameter int CNT_W = TICK_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*CNT_W-1:0] max_count,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       oneshot,
    input  logic [N_CH-1:0]       start,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ch_en    (ch_en[i]),
            .oneshot  (oneshot[i]),
            .start    (start[i]),
            .max_count(max_count[slice_lo(i, CNT_W) +: CNT_W]),
            .tick     (tick[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: fixed vector table, directed
// corner-case sequences and randomized traffic against a countdown model.
module tb_multi_tick_gen;

    localparam int N_CH  = 4;
    localparam int CNT_W = 26;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH*CNT_W-1:0] max_count;
    logic [N_CH-1:0]       ch_en, oneshot, start;
    logic [N_CH-1:0]       tick, busy;

    multi_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .max_count(max_count),
        .ch_en    (ch_en),
        .oneshot  (oneshot),
        .start    (start),
        .tick     (tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a channel is either running or not; while running it
    // knows how many more edges remain until its tick.
    logic           m_run  [N_CH];
    longint         m_left [N_CH];
    logic [N_CH-1:0] m_tick;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            m_run[i]  = 1'b0;
            m_left[i] = 0;
        end
        m_tick = '0;
    end

    function automatic longint mc_of(input int ch);
        return longint'(max_count[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < N_CH; i++) begin
            m_tick[i] = 1'b0;
            if (reset || !ch_en[i]) begin
                m_run[i] = 1'b0;
            end else if (start[i] || (!m_run[i] && !oneshot[i])) begin
                m_run[i]  = 1'b1;
                m_left[i] = mc_of(i) + 1;
            end else if (m_run[i]) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    if (oneshot[i]) m_run[i] = 1'b0;
                    else            m_left[i] = mc_of(i) + 1;
                end
            end
        end
    endtask

    function automatic logic [N_CH-1:0] m_busy();
        logic [N_CH-1:0] b;
        for (int i = 0; i < N_CH; i++) b[i] = m_run[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("model_tick", 32'(tick), 32'(m_tick));
        chk("model_busy", 32'(busy), 32'(m_busy()));
    endtask

    task automatic set_mc(input int ch, input int v);
        max_count[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; ch_en = '0; oneshot = '0; start = '0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] en, os, st;
        int              mc;
        logic [N_CH-1:0] exp_tick, exp_busy;
    } vec_t;

    vec_t vt[$];
    int   tick_at[$];
    int   entry;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ch_en = '0; oneshot = '0; start = '0; max_count = '0;

        // ch1 one-shot period 5, then ch0 periodic period 3
        vt.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 5, 4'h0, 4'h0});
        vt.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 5, 4'h0, 4'h0});
        vt.push_back('{1'b0, 4'h2, 4'h2, 4'h2, 5, 4'h0, 4'h2});
        for (int j = 0; j < 5; j++)
            vt.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 5, 4'h0, 4'h2});
        vt.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 5, 4'h2, 4'h0});
        vt.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 5, 4'h0, 4'h0});
        vt.push_back('{1'b0, 4'h0, 4'h2, 4'h2, 5, 4'h0, 4'h0});
        vt.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 5, 4'h0, 4'h0});
        vt.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 3, 4'h0, 4'h1});
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++)
                vt.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 3, 4'h0, 4'h1});
            vt.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 3, 4'h1, 4'h1});
        end
        vt.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 3, 4'h0, 4'h0});

        foreach (vt[k]) begin
            reset = vt[k].rst; ch_en = vt[k].en; oneshot = vt[k].os; start = vt[k].st;
            for (int i = 0; i < N_CH; i++) set_mc(i, vt[k].mc);
            step();
            chk("vec_tick", 32'(tick), 32'(vt[k].exp_tick));
            chk("vec_busy", 32'(busy), 32'(vt[k].exp_busy));
        end

        // Period change mid-count: current interval 10, following ones 3
        do_reset();
        ch_en = 4'h1; set_mc(0, 9);
        step(); entry = cyc;
        repeat (4) step();
        set_mc(0, 2);
        for (int j = 0; j < 20; j++) begin
            step();
            if (tick[0]) tick_at.push_back(cyc);
        end
        chk("chg_count", 32'(tick_at.size() >= 3), 32'd1);
        if (tick_at.size() >= 3) begin
            chk("chg_first", 32'(tick_at[0] - entry), 32'd10);
            chk("chg_second", 32'(tick_at[1] - tick_at[0]), 32'd3);
            chk("chg_third", 32'(tick_at[2] - tick_at[1]), 32'd3);
        end

        // Restart coincident with terminal count suppresses the tick
        do_reset();
        ch_en = 4'h1; set_mc(0, 4);
        step();
        repeat (4) step();
        start = 4'h1;
        step();
        chk("rst_tc_tick", 32'(tick[0]), 32'd0);
        chk("rst_tc_busy", 32'(busy[0]), 32'd1);
        start = 4'h0;
        repeat (4) begin
            step();
            chk("rst_tc_quiet", 32'(tick[0]), 32'd0);
        end
        step();
        chk("rst_tc_next", 32'(tick[0]), 32'd1);

        // Period 0: tick every cycle, disable drops it at once
        do_reset();
        ch_en = 4'h4; set_mc(2, 0);
        step();
        chk("p0_entry_tick", 32'(tick[2]), 32'd0);
        chk("p0_entry_busy", 32'(busy[2]), 32'd1);
        repeat (5) begin
            step();
            chk("p0_tick", 32'(tick[2]), 32'd1);
        end
        ch_en = 4'h0;
        step();
        chk("p0_off_tick", 32'(tick[2]), 32'd0);
        chk("p0_off_busy", 32'(busy[2]), 32'd0);

        // Reset while all channels are mid-count
        do_reset();
        ch_en = 4'hF; set_mc(0, 3); set_mc(1, 5); set_mc(2, 7); set_mc(3, 2);
        repeat (6) step();
        reset = 1'b1;
        step();
        chk("rmid_tick", 32'(tick), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        chk("rmid_after_tick", 32'(tick), 32'd0);
        chk("rmid_after_busy", 32'(busy), 32'hF);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk("rmid_ch1", 32'(tick[1]), 32'(j == 6));
        end

        // Randomized traffic against the model
        do_reset();
        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) ch_en   = N_CH'($urandom);
            if ($urandom_range(0, 23) == 0) oneshot = N_CH'($urandom);
            for (int i = 0; i < N_CH; i++) begin
                start[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 5) == 0) set_mc(i, int'($urandom_range(0, 7)));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
